vc_fifo_cond_bank: RTL

//  Multi-channel conditional FIFO bank for the QoS/VC datapath. Generalises the single

---
 rtl/vc_fifo_cond_bank.sv | 82 ++++++++
 1 files changed

// File: rtl/vc_fifo_cond_bank.sv
// vc_fifo_cond_bank: NVC-queue FIFO bank with shared runtime thresholds and per-VC flags.
// Define VCF_STICKY_ERR_EN to hold error flags until reset instead of pulsing them.
module vc_fifo_cond_bank #(
    parameter int BW = 6,
    parameter int DEPTH_LOG2 = 2,
    parameter int NVC = 4,
    parameter int VCW = 2,
    parameter int CW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [VCW-1:0]    wr_vc,
    input  logic [BW-1:0]     data_in,
    input  logic              rd,
    input  logic [VCW-1:0]    rd_vc,
    input  logic [CW-1:0]     umbral_bajo,
    input  logic [CW-1:0]     umbral_alto,
    output logic [BW-1:0]     data_out,
    output logic              data_out_vld,
    output logic [NVC-1:0]    full,
    output logic [NVC-1:0]    empty,
    output logic [NVC-1:0]    almost_full,
    output logic [NVC-1:0]    almost_empty,
    output logic [NVC-1:0]    error,
    output logic [NVC*CW-1:0] occupancy
);
    localparam int D = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    logic [BW-1:0] mem [NVC][D];
    logic [DEPTH_LOG2-1:0] wptr [NVC];
    logic [DEPTH_LOG2-1:0] rptr [NVC];
    logic [CW-1:0] cnt [NVC];
    logic wr_in, rd_in, wr_go, rd_go;
    logic [NVC-1:0] inc, dec, ev;
    // A same-VC read frees the slot a full-queue write needs; an empty-queue read never falls through.
    always_comb begin
        wr_in = wr && ({1'b0, wr_vc} < (VCW+1)'(NVC));
        rd_in = rd && ({1'b0, rd_vc} < (VCW+1)'(NVC));
        rd_go = rd_in && !empty[rd_vc];
        wr_go = wr_in && (!full[wr_vc] || (rd_go && rd_vc == wr_vc));
    end
    genvar v;
    for (v = 0; v < NVC; v++) begin : g_vc
        assign full[v] = cnt[v] == CW'(D);
        assign empty[v] = cnt[v] == '0;
        assign almost_full[v] = umbral_alto != '0 && cnt[v] >= umbral_alto;
        assign almost_empty[v] = cnt[v] <= umbral_bajo;
        assign occupancy[v*CW +: CW] = cnt[v];
        assign inc[v] = wr_go && wr_vc == VCW'(v);
        assign dec[v] = rd_go && rd_vc == VCW'(v);
        assign ev[v] = (wr_in && !wr_go && wr_vc == VCW'(v)) || (rd_in && !rd_go && rd_vc == VCW'(v));
    end
    always_ff @(posedge clk) begin
        if (wr_go) mem[wr_vc][wptr[wr_vc]] <= data_in;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NVC; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i] <= '0;
            end
            data_out <= '0;
            data_out_vld <= 1'b0;
            error <= '0;
        end else begin
            data_out_vld <= rd_go;
            if (rd_go) begin
                data_out <= mem[rd_vc][rptr[rd_vc]];
                rptr[rd_vc] <= rptr[rd_vc] + PTR_ONE;
            end
            if (wr_go) wptr[wr_vc] <= wptr[wr_vc] + PTR_ONE;
            for (int i = 0; i < NVC; i++) cnt[i] <= cnt[i] + CW'(inc[i]) - CW'(dec[i]);
`ifdef VCF_STICKY_ERR_EN
            error <= error | ev;
`else
            error <= ev;
`endif
        end
    end
endmodule
